// File: rtl/mem_pkg.sv
// Shared types and constants for the unified instruction/data memory controller.
// Contents: FSM state type, memwrite encodings, array word width and a small
// helper that tells whether a memwrite code stores to the array.
package mem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        DBUSY,
        IBUSY,
        DONE
    } state_t;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_WORD = 2'b01;
    localparam logic [1:0] MW_FULL = 2'b10;

    // Code 11 is reserved and behaves as a read.
    function automatic logic mw_is_write(input logic [1:0] mw);
        return (mw == MW_WORD) || (mw == MW_FULL);
    endfunction

endpackage

// File: rtl/mem_arb_ctrl_if.sv
// Core-side bus of mem_arb_ctrl: data port, instruction-fetch port, stall
// (abort) flags and the debug read port.
//   master : the core / bench (drives requests, addresses, store data, checkma)
//   slave  : the controller (drives readdata, instr, aborts, checkm)
interface mem_arb_ctrl_if
    import mem_pkg::*;
#(
    parameter int unsigned N   = 64,
    parameter int unsigned CAW = 8
);

    logic              datareq;
    logic [1:0]        memwrite;
    logic [N-1:0]      dataadr;
    logic [N-1:0]      writedata;
    logic [N-1:0]      readdata;
    logic              instrreq;
    logic [WORD_W-1:0] instradr;
    logic [WORD_W-1:0] instr;
    logic              instrabort;
    logic              dataabort;
    logic [CAW-1:0]    checkma;
    logic [WORD_W-1:0] checkm;

    modport master (
        output datareq, memwrite, dataadr, writedata, instrreq, instradr, checkma,
        input  readdata, instr, instrabort, dataabort, checkm
    );

    modport slave (
        input  datareq, memwrite, dataadr, writedata, instrreq, instradr, checkma,
        output readdata, instr, instrabort, dataabort, checkm
    );

endinterface

// File: rtl/mem_array.sv
// DEPTH x 32-bit word array.
//   clk_i      : clock
//   we_i       : write enable for the access port
//   wide_i     : write the word pair {idx|1, idx} instead of the single word idx
//   idx_i      : access word index (even when wide_i is used)
//   wdata_i    : store data, low word goes to idx_i
//   rdata_o    : {word idx|1, word idx}, combinational; the controller registers it
//   dbg_idx_i  : debug word index
//   dbg_data_o : debug word, combinational
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter string       INIT_FILE = "memfile.dat",
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic                wide_i,
    input  logic [AW-1:0]       idx_i,
    input  logic [2*WORD_W-1:0] wdata_i,
    output logic [2*WORD_W-1:0] rdata_o,
    input  logic [AW-1:0]       dbg_idx_i,
    output logic [WORD_W-1:0]   dbg_data_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     idx_hi;

    assign idx_hi = idx_i | AW'(1);

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i[WORD_W-1:0];
            if (wide_i) begin
                mem_q[idx_hi] <= wdata_i[2*WORD_W-1:WORD_W];
            end
        end
    end

    assign rdata_o    = {mem_q[idx_hi], mem_q[idx_i]};
    assign dbg_data_o = mem_q[dbg_idx_i];

endmodule

// File: rtl/mem_arb_ctrl.sv
// Unified instruction/data memory controller: serves the core's fetch and data
// ports from one single-ported array with WAIT extra cycles per access,
// round-robin arbitration, fetch cancellation and a debug read port.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : core-side bus (slave modport), see mem_arb_ctrl_if
module mem_arb_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned N         = 64,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned WAIT      = 1,
    parameter int unsigned CAW       = 8,
    parameter string       INIT_FILE = "memfile.dat"
) (
    input logic           clk,
    input logic           reset,
    mem_arb_ctrl_if.slave bus
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PAIR_W = 2 * WORD_W;
    localparam bit          WIDE   = (N == 64);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic              done_data_q, done_data_d;
    logic              done_instr_q, done_instr_d;
    logic [N-1:0]      readdata_q, readdata_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] adr_q, adr_d;
    logic [1:0]        mw_q, mw_d;
    logic [N-1:0]      wdata_q, wdata_d;

    logic              we;
    logic              pair;
    logic [AW-1:0]     idx;
    logic [PAIR_W-1:0] rdata;
    logic              unused_adr;

    // Only the word-index bits of dataadr matter; the rest is ignored.
    assign unused_adr = ^bus.dataadr;

    // 64-bit data accesses (except 32-bit word writes) address an aligned pair.
    assign pair = (state_q == DBUSY) && WIDE && (mw_q != MW_WORD);
    assign idx  = pair ? {adr_q[AW+1:3], 1'b0} : adr_q[AW+1:2];

    mem_array #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk_i      (clk),
        .we_i       (we),
        .wide_i     (pair),
        .idx_i      (idx),
        .wdata_i    (PAIR_W'(wdata_q)),
        .rdata_o    (rdata),
        .dbg_idx_i  (AW'(bus.checkma)),
        .dbg_data_o (bus.checkm)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        done_data_d  = 1'b0;
        done_instr_d = 1'b0;
        readdata_d   = readdata_q;
        instr_d      = instr_q;
        adr_d        = adr_q;
        mw_d         = mw_q;
        wdata_d      = wdata_q;
        we           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.datareq && (!bus.instrreq || !rr_q)) begin
                    state_d = DBUSY;
                    adr_d   = bus.dataadr[WORD_W-1:0];
                    mw_d    = bus.memwrite;
                    wdata_d = bus.writedata;
                    cnt_d   = 4'(WAIT);
                end else if (bus.instrreq) begin
                    state_d = IBUSY;
                    adr_d   = bus.instradr;
                    cnt_d   = 4'(WAIT);
                end
            end
            DBUSY: begin
                // Never cancelled: a write commits even if datareq has dropped.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    we = mw_is_write(mw_q);
                    if (!we) begin
                        readdata_d = N'(rdata);
                    end
                    state_d     = DONE;
                    done_data_d = 1'b1;
                end
            end
            IBUSY: begin
                // Redirect or dropped request abandons the fetch.
                if (!bus.instrreq || (bus.instradr != adr_q)) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    instr_d      = rdata[WORD_W-1:0];
                    state_d      = DONE;
                    done_instr_d = 1'b1;
                end
            end
            DONE: begin
                // Single cycle, accepts nothing; favour the other port next time.
                state_d = IDLE;
                rr_d    = done_data_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            rr_q         <= 1'b0;
            done_data_q  <= 1'b0;
            done_instr_q <= 1'b0;
            readdata_q   <= '0;
            instr_q      <= '0;
            adr_q        <= '0;
            mw_q         <= MW_NONE;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            done_data_q  <= done_data_d;
            done_instr_q <= done_instr_d;
            readdata_q   <= readdata_d;
            instr_q      <= instr_d;
            adr_q        <= adr_d;
            mw_q         <= mw_d;
            wdata_q      <= wdata_d;
        end
    end

    assign bus.readdata   = readdata_q;
    assign bus.instr      = instr_q;
    assign bus.dataabort  = bus.datareq & ~((state_q == DONE) & done_data_q);
    assign bus.instrabort = bus.instrreq & ~((state_q == DONE) & done_instr_q);

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Scoreboard bench for mem_arb_ctrl: drivers push expected responses computed
// from a word-array reference model; a negedge monitor pops them whenever a
// request completes (request high, abort low).
module tb_mem_arb_ctrl;
    import mem_pkg::*;

    localparam int unsigned N     = 64;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned WAIT  = 3;
    localparam int unsigned CAW   = 8;
    localparam int unsigned TMO   = 200;

    typedef struct {
        bit          rd;
        logic [63:0] val;
    } dexp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arb_ctrl_if #(.N(N), .CAW(CAW)) bus ();

    mem_arb_ctrl #(
        .N         (N),
        .DEPTH     (DEPTH),
        .WAIT      (WAIT),
        .CAW       (CAW),
        .INIT_FILE ("")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [DEPTH];
    dexp_t       exp_d [$];
    logic [31:0] exp_i [$];
    byte         order_log [$];
    int          drun = 0, irun = 0, dmax = 0, imax = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int widx(input logic [63:0] adr);
        return int'((adr >> 2) % DEPTH);
    endfunction

    function automatic int pidx(input logic [63:0] adr);
        return int'(((adr >> 3) % (DEPTH / 2)) * 2);
    endfunction

    // Monitor: every completion must match the oldest expectation of its port.
    always @(negedge clk) begin
        dexp_t e;
        if (reset) begin
            if (bus.datareq && !bus.dataabort) begin
                order_log.push_back("D");
                if (exp_d.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL data_unexpected actual=completion required=none");
                end else begin
                    e = exp_d.pop_front();
                    if (e.rd) check("readdata", bus.readdata, e.val);
                end
            end
            if (bus.instrreq && !bus.instrabort) begin
                order_log.push_back("I");
                if (exp_i.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL instr_unexpected actual=completion required=none");
                end else begin
                    check("instr", {32'h0, bus.instr}, {32'h0, exp_i.pop_front()});
                end
            end
            drun = (bus.datareq && bus.dataabort) ? drun + 1 : 0;
            irun = (bus.instrreq && bus.instrabort) ? irun + 1 : 0;
            if (drun > dmax) dmax = drun;
            if (irun > imax) imax = irun;
        end
    end

    task automatic data_access(input logic [1:0] mw, input logic [63:0] adr,
                               input logic [63:0] wd);
        int k;
        int stalls = 0;
        bit ok = 0;
        dexp_t e;
        @(posedge clk); #1;
        bus.datareq = 1'b1; bus.memwrite = mw; bus.dataadr = adr; bus.writedata = wd;
        e.rd = 1'b0; e.val = '0;
        k = pidx(adr);
        if (mw == MW_WORD) begin
            model[widx(adr)] = wd[31:0];
        end else if (mw == MW_FULL) begin
            model[k] = wd[31:0]; model[k+1] = wd[63:32];
        end else begin
            e.rd = 1'b1; e.val = {model[k+1], model[k]};
        end
        exp_d.push_back(e);
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (!bus.dataabort) begin ok = 1; break; end
            stalls++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL data_timeout actual=no completion required=completion in %0d", TMO);
        end else begin
            check("data_stalls", 64'(stalls), 64'(WAIT + 2));
        end
        @(posedge clk); #1;
        bus.datareq = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] adr, input bit hold_extra);
        int stalls = 0;
        bit ok = 0;
        @(posedge clk); #1;
        bus.instrreq = 1'b1; bus.instradr = adr;
        exp_i.push_back(model[widx({32'h0, adr})]);
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (!bus.instrabort) begin ok = 1; break; end
            stalls++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL fetch_timeout actual=no completion required=completion in %0d", TMO);
        end else begin
            check("fetch_stalls", 64'(stalls), 64'(WAIT + 2));
        end
        if (hold_extra) begin
            // Request still held: the completion must not repeat next cycle.
            @(negedge clk);
            check("done_one_cycle", {63'h0, bus.instrabort}, 64'h1);
        end
        @(posedge clk); #1;
        bus.instrreq = 1'b0;
    endtask

    task automatic check_dbg(input int idx, input string name);
        bus.checkma = CAW'(idx);
        #1;
        check(name, {32'h0, bus.checkm}, {32'h0, model[idx]});
    endtask

    initial begin
        logic [31:0] old_word;
        bit          ok;
        byte         want [4];
        want = '{"D", "I", "D", "I"};
        bus.datareq = 1'b0; bus.memwrite = MW_NONE; bus.dataadr = '0; bus.writedata = '0;
        bus.instrreq = 1'b0; bus.instradr = '0; bus.checkma = '0;

        // Reset state; aborts follow requests even in reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", bus.readdata, 64'h0);
        check("rst_instr", {32'h0, bus.instr}, 64'h0);
        bus.datareq = 1'b1; bus.instrreq = 1'b1;
        #1;
        check("rst_dataabort", {63'h0, bus.dataabort}, 64'h1);
        check("rst_instrabort", {63'h0, bus.instrabort}, 64'h1);
        bus.datareq = 1'b0; bus.instrreq = 1'b0;
        @(negedge clk); reset = 1'b1;

        // Fill the array with known contents.
        for (int k = 0; k < DEPTH / 2; k++) begin
            data_access(MW_FULL, 64'(k * 8), {$urandom, $urandom});
        end
        for (int i = 0; i < 6; i++) check_dbg($urandom_range(0, DEPTH - 1), "dbg_fill");

        // Fetch from 0x04 with the request held one cycle past completion.
        data_access(MW_WORD, 64'h4, 64'h0000_0000_2008_0005);
        fetch(32'h4, 1'b1);
        check("fetch_0x04", {32'h0, bus.instr}, 64'h2008_0005);

        // 64-bit store/load, little-endian word pair.
        data_access(MW_FULL, 64'h10, 64'h1122_3344_5566_7788);
        data_access(MW_NONE, 64'h10, 64'h0);
        check("rd64_value", bus.readdata, 64'h1122_3344_5566_7788);
        bus.checkma = 8'd4; #1;
        check("dbg_word4", {32'h0, bus.checkm}, 64'h5566_7788);
        bus.checkma = 8'd5; #1;
        check("dbg_word5", {32'h0, bus.checkm}, 64'h1122_3344);

        // Address wrap: 0x400 lands on word 0.
        data_access(MW_WORD, 64'h400, 64'hdead_beef_0bad_cafe);
        bus.checkma = 8'd0; #1;
        check("wrap_word0", {32'h0, bus.checkm}, 64'h0bad_cafe);

        // Fetch redirected 0x08 -> 0x40 one cycle into the busy period.
        data_access(MW_WORD, 64'h08, 64'haaaa_0008);
        data_access(MW_WORD, 64'h40, 64'h5555_0040);
        @(posedge clk); #1;
        bus.instrreq = 1'b1; bus.instradr = 32'h08;
        exp_i.push_back(model[16]);
        @(posedge clk); @(posedge clk); #1;
        bus.instradr = 32'h40;
        ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (!bus.instrabort) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL cancel_timeout actual=no completion required=completion");
        end
        check("cancel_instr", {32'h0, bus.instr}, 64'h5555_0040);
        @(posedge clk); #1;
        bus.instrreq = 1'b0;

        // Randomised single-port traffic.
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 4))
                0: fetch($urandom, 1'b0);
                1: data_access(MW_NONE, {$urandom, $urandom}, 64'h0);
                2: data_access(MW_WORD, {$urandom, $urandom}, {$urandom, $urandom});
                3: data_access(MW_FULL, {$urandom, $urandom}, {$urandom, $urandom});
                default: data_access(2'b11, {$urandom, $urandom}, {$urandom, $urandom});
            endcase
            if (t % 10 == 0) check_dbg($urandom_range(0, DEPTH - 1), "dbg_random");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Reset in the middle of a pending write: nothing committed.
        bus.checkma = 8'h20;
        old_word = model[8'h20];
        @(posedge clk); #1;
        bus.datareq = 1'b1; bus.memwrite = MW_WORD; bus.dataadr = 64'h80;
        bus.writedata = {32'h0, ~old_word};
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        bus.datareq = 1'b0;
        check("rst_mid_readdata", bus.readdata, 64'h0);
        check("rst_mid_instr", {32'h0, bus.instr}, 64'h0);
        repeat (WAIT + 3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        check("rst_mid_word", {32'h0, bus.checkm}, {32'h0, old_word});
        fetch(32'h80, 1'b0);

        // Both ports held: strict alternation starting with data.
        @(posedge clk); #1;
        order_log.delete(); dmax = 0; imax = 0;
        for (int i = 0; i < 2; i++) begin
            exp_d.push_back('{rd: 1'b1, val: {model[5], model[4]}});
            exp_i.push_back(model[12]);
        end
        bus.datareq = 1'b1; bus.memwrite = MW_NONE; bus.dataadr = 64'h10;
        bus.instrreq = 1'b1; bus.instradr = 32'h30;
        ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (order_log.size() >= 4) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL arb_timeout actual=%0d completions required=4", order_log.size());
        end
        @(posedge clk); #1;
        bus.datareq = 1'b0; bus.instrreq = 1'b0;
        for (int i = 0; i < 4 && i < order_log.size(); i++) begin
            check($sformatf("arb_order%0d", i), 64'(order_log[i]), 64'(want[i]));
        end
        // Worst wait: the other port's full access, its DONE cycle and our own access.
        check("arb_dmax_ok", {63'h0, (dmax <= 2 * (WAIT + 2) + 1)}, 64'h1);
        check("arb_imax_ok", {63'h0, (imax <= 2 * (WAIT + 2) + 1)}, 64'h1);
        check("sb_empty", 64'(exp_d.size() + exp_i.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
